// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, default width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the remainder/quotient
// pair left by one, try subtracting the divisor, keep the difference if it did not borrow.
module md_div_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, div};
    // the remainder stays below the divisor, so a borrow always shows up in the top bit
    fits     = ~trial[WIDTH];
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, with signs applied in a single fix-up cycle.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write here, mul/div latch operands
// CALC  | one shift-add or shift-subtract iteration per clock, ITER clocks
// FIX   | apply signs, write hi/lo, raise done for the following cycle
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  md_state_e          state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_hold;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;

  logic               op_signed;
  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start && !op[2]) state_next = CALC;
      CALC:    if (count == CW'(ITER - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // magnitudes are kept as plain WIDTH-bit unsigned values, so the most negative
  // operand maps to 2^(WIDTH-1) without needing an extra bit
  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    in_sign_a = op_signed & a[WIDTH-1];
    in_sign_b = op_signed & b[WIDTH-1];
    in_mag_a  = in_sign_a ? (~a + 1'b1) : a;
    in_mag_b  = in_sign_b ? (~b + 1'b1) : b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .div      (mag_b),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  always_comb begin
    prod_fixed = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo_fixed  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fixed  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mag_b  <= '0;
      a_hold <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == MD_MTHI) begin
              hi <= a;
            end else if (op == MD_MTLO) begin
              lo <= a;
            end else if (!op[2]) begin
              count  <= '0;
              acc    <= {{WIDTH{1'b0}}, in_mag_a};
              mag_b  <= in_mag_b;
              a_hold <= a;
              is_div <= op[1];
              sign_a <= in_sign_a;
              sign_b <= in_sign_b;
            end
          end
        end
        CALC: begin
          count <= count + CW'(1);
          acc   <= is_div ? {div_rem_next, div_quo_next} : mul_next;
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end else if (mag_b == '0) begin
            hi <= a_hold;
            lo <= '1;
          end else begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops checked
// against an arithmetic reference model of HI/LO.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  md_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Reference: HI/LO after one operation, using 64-bit arithmetic on the raw operands.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint          sx, sy, p, q, r;
    longint unsigned pu;
    rh = hi_in;
    rl = lo_in;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'b000: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      3'b001: begin pu = {32'b0, x} * {32'b0, y}; rh = pu[63:32]; rl = pu[31:0]; end
      3'b010: begin
        if (y == 32'd0) begin rl = 32'hFFFF_FFFF; rh = x; end
        else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
      end
      3'b011: begin
        if (y == 32'd0) begin rl = 32'hFFFF_FFFF; rh = x; end
        else begin rl = x / y; rh = x % y; end
      end
      3'b100: rh = x;
      3'b101: rl = x;
      default: ;
    endcase
  endfunction

  // Issue a mul/div at the current negedge and follow it until busy falls.
  // Returns at the negedge of the first non-busy cycle (the done cycle).
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int nbusy, output logic done_early, output logic hl_moved,
                       output logic timeout);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    nbusy = 0; done_early = 1'b0; hl_moved = 1'b0; timeout = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    for (int i = 0; i < 80; i++) begin
      if (!busy) begin timeout = 1'b0; break; end
      nbusy++;
      if (done) done_early = 1'b1;
      if (hi !== h0 || lo !== l0) hl_moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_assert++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_assert++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_plan_vectors;
    logic [2:0]  vo [5];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] eh [5];
    logic [31:0] el [5];
    int nb; logic de, hm, to;
    vo = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV};
    va = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
    vb = '{32'h3, 32'h3, 32'h2, 32'h0, 32'hFFFF_FFFF};
    eh = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000};
    el = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int k = 0; k < 5; k++) begin
      do_op(vo[k], va[k], vb[k], nb, de, hm, to);
      n_assert++; if (to) begin n_fail++; $display("FAIL plan%0d_timeout: got busy stuck, want idle", k); end
      n_assert++; if (nb != 33) begin n_fail++; $display("FAIL plan%0d_busy_cycles: got %0d want 33", k, nb); end
      n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL plan%0d_done: got %b want 1", k, done); end
      n_assert++; if (hi !== eh[k]) begin n_fail++; $display("FAIL plan%0d_hi: got %h want %h", k, hi, eh[k]); end
      n_assert++; if (lo !== el[k]) begin n_fail++; $display("FAIL plan%0d_lo: got %h want %h", k, lo, el[k]); end
      n_assert++; if (de || hm) begin n_fail++; $display("FAIL plan%0d_during_busy: got done=%b hilo_moved=%b want 0 0", k, de, hm); end
      @(negedge clk);
      n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL plan%0d_done_pulse: got %b want 0", k, done); end
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] h0, l0;
    start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    n_assert++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done); end
    op = MD_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    n_assert++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); end
    n_assert++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0 0", busy, done); end
    h0 = 32'h1234_5678; l0 = 32'h9ABC_DEF0;
    for (int k = 6; k < 8; k++) begin
      op = 3'(k); a = $urandom; b = $urandom;
      @(negedge clk);
      n_assert++;
      if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
        n_fail++; $display("FAIL nop%0d: got busy=%b hi=%h lo=%h want 0 %h %h", k, busy, hi, lo, h0, l0);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int n;
    start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    op = MD_MTLO; a = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 60) begin n++; @(negedge clk); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ign_timeout: got busy stuck, want idle"); end
    n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_ign_done: got %b want 1", done); end
    n_assert++; if (hi !== 32'h0 || lo !== 32'd35) begin n_fail++; $display("FAIL busy_ign_result: got %h_%h want 00000000_00000023", hi, lo); end
    @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ign_no_restart: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y, eh, el, dummy_h, dummy_l;
    int nb; logic de, hm, to;
    x = $urandom; y = $urandom;
    do_op(MD_MULT, x, y, nb, de, hm, to);
    ref_md(MD_MULT, x, y, 32'h0, 32'h0, eh, el);
    n_assert++; if (to || done !== 1'b1 || hi !== eh || lo !== el) begin
      n_fail++; $display("FAIL b2b_first: got done=%b %h_%h want 1 %h_%h", done, hi, lo, eh, el);
    end
    x = $urandom; y = 32'($urandom_range(1, 1000));
    do_op(MD_DIV, x, y, nb, de, hm, to);
    ref_md(MD_DIV, x, y, dummy_h, dummy_l, eh, el);
    n_assert++; if (to || nb != 33) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 33", nb); end
    n_assert++; if (hi !== eh || lo !== el) begin n_fail++; $display("FAIL b2b_second: got %h_%h want %h_%h", hi, lo, eh, el); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] mh, ml, eh, el, x, y;
    logic [2:0]  o;
    int nb; logic de, hm, to;
    start = 1'b1; op = MD_MTHI; a = 32'h1111_1111;
    @(negedge clk);
    op = MD_MTLO; a = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    mh = 32'h1111_1111; ml = 32'h2222_2222;
    for (int it = 0; it < 60; it++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: x = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF;
        3: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      ref_md(o, x, y, mh, ml, eh, el);
      if (!o[2]) begin
        do_op(o, x, y, nb, de, hm, to);
        n_assert++;
        if (to || nb != 33 || done !== 1'b1 || de || hm) begin
          n_fail++; $display("FAIL rand%0d_timing: got busy=%0d done=%b early=%b moved=%b want 33 1 0 0", it, nb, done, de, hm);
        end
        n_assert++;
        if (hi !== eh || lo !== el) begin
          n_fail++; $display("FAIL rand%0d_op%0d a=%h b=%h: got %h_%h want %h_%h", it, o, x, y, hi, lo, eh, el);
        end
        @(negedge clk);
      end else begin
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        n_assert++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== eh || lo !== el) begin
          n_fail++; $display("FAIL rand%0d_op%0d: got busy=%b done=%b %h_%h want 0 0 %h_%h", it, o, busy, done, hi, lo, eh, el);
        end
      end
      mh = eh; ml = el;
    end
  endtask

  task automatic test_abort_reset;
    logic saw;
    int nb; logic de, hm, to;
    start = 1'b1; op = MD_MTHI; a = 32'hA5A5_A5A5;
    @(negedge clk);
    op = MD_MTLO; a = 32'h5A5A_5A5A;
    @(negedge clk);
    op = MD_MULT; a = 32'h0012_3457; b = 32'hFFFF_0F0F;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_assert++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw = 1'b1;
      @(negedge clk);
    end
    n_assert++; if (saw) begin n_fail++; $display("FAIL abort_no_done: got activity after reset, want none"); end
    do_op(MD_DIVU, 32'd100, 32'd7, nb, de, hm, to);
    n_assert++; if (to || nb != 33) begin n_fail++; $display("FAIL after_abort_busy: got %0d want 33", nb); end
    n_assert++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL after_abort_divu: got %h_%h want 00000002_0000000e", hi, lo); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_mthi_mtlo();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit in the execute stage, next to the ALU.
- Consumes the same operand pair the ALU receives: A = rs, B = rt.
- Produces the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Asserts busy so control can stall the PC; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, iteration cycles per multiply or divide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op
- a  input  WIDTH  operand 1 (rs)
- b  input  WIDTH  operand 2 (rt)
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse after HI/LO are written by mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock, asynchronous active-high reset (rst).
  - Effect: state=IDLE, count=0, hi=0, lo=0, done=0, busy=0.
  - rst mid-operation aborts the computation; HI/LO are cleared and no done pulse is produced.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MTHI or MTLO:
  - hi<=a (MTHI) or lo<=a (MTLO) at that edge.
  - Stays IDLE; no busy, no done.
- IDLE, start=1, op in 000..011:
  - Latch |a|, |b| for signed ops (raw a, b for unsigned ops), plus sign flags.
  - count<=0; go to CALC.
- IDLE, start=1, op 110/111: ignored.
- CALC:
  - One iteration per edge; count increments.
  - When count==ITER-1 at an edge, go to FIX.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- FIX, one edge:
  - Apply signs and write hi/lo.
  - done<=1 for exactly the following cycle.
  - Go to IDLE.
- Latency:
  - busy is high for ITER+1 = 33 cycles, starting the cycle after the start edge.
  - done is high on cycle 34 after the start edge, with busy=0.
  - New hi/lo are visible on the same cycle as done.
- Signed results:
  - Product is negated (2*WIDTH two's complement) when sign(a) xor sign(b).
  - Quotient takes sign(a) xor sign(b); remainder takes sign(a).
  - Results are truncated toward zero.
- Output mapping:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b==0):
  - Full latency.
  - lo = all ones (0xFFFFFFFF), hi = a unchanged, for both DIV and DIVU.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Magnitude 0x80000000 is handled as unsigned WIDTH bits, with no extra bit lost.
- start while busy: ignored entirely, MTHI/MTLO included; operands are not re-latched.
  - Control must hold the instruction stalled until busy=0.
- hi/lo never change during CALC.
  - An MFHI issued during busy reads the old value; the stall is control's responsibility.
- start asserted in the same cycle done is high: accepted normally, since state is IDLE.
- No overflow or exception outputs; overflow is ignored, consistent with the ALU.

Decomposition:
- Shared package md_pkg holds:
  - op code localparams MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encoding IDLE/CALC/FIX;
  - the WIDTH default.
- One natural sub-module: md_div_step.
  - Combinational single restoring-divide iteration: remainder/quotient in, next remainder/quotient out.
  - Instantiated once in md_unit.
- The multiply step stays inline.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> busy 33 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFE, b=3 -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 in the next cycle -> hi/lo update on each start edge with busy=0 and done=0. MTHI issued during an active MULT -> ignored; hi = MULT result afterwards.
- MULT started, rst pulsed asynchronously mid-cycle at iteration 10 -> busy drops immediately, hi=lo=0, no done pulse. A fresh DIVU 100/7 after reset -> lo=14, hi=2.
